// File: rtl/ahblite_mem_slave.sv
// AHB-Lite memory responder: word-organised array with configurable wait states,
// byte-lane writes and the two-cycle ERROR response for illegal accesses.
module ahblite_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned ADDR_MSB = ADDR_WIDTH + 1;
  localparam int unsigned LANES    = 4;
  localparam logic [1:0]  WAIT_INIT = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_cnt;
  logic [1:0]              w_next_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [LANES-1:0]        r_mask;
  logic                    r_hreadyout;
  logic                    r_hresp;
  logic [31:0]             r_hrdata;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_can_accept;
  logic                    w_accept;
  logic                    w_illegal;
  logic [LANES-1:0]        w_mask;
  logic                    w_do_write;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic [31:0]             w_rd_word;
  logic                    w_next_read;
  logic                    w_next_hreadyout;
  logic                    w_next_hresp;
  logic [31:0]             w_next_hrdata;

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

  // New address phases can only be taken while this slave is not stalling the bus.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept     = w_can_accept && HSEL && HREADY && (HTRANS inside {2'b10, 2'b11});
  assign w_illegal    = ((HADDR >> (ADDR_WIDTH + 2)) != 32'd0) ||
                        (HSIZE > 3'b010) ||
                        ((HSIZE == 3'b001) && HADDR[0]) ||
                        ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign w_do_write   = (r_state == S_DATA) && r_write;

  // Little-endian byte-lane enables.
  always_comb begin
    w_mask = '0;
    case (HSIZE)
      3'b000:  w_mask = LANES'(4'b0001 << HADDR[1:0]);
      3'b001:  w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_mask = 4'b1111;
      default: w_mask = '0;
    endcase
  end

  // Read word with the completing write forwarded, so a back-to-back read sees it.
  always_comb begin
    w_rd_addr = (r_state == S_WAIT) ? r_addr : HADDR[ADDR_MSB:ADDR_LSB];
    w_rd_word = r_mem[w_rd_addr];
    if (w_do_write && (r_addr == w_rd_addr)) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (r_mask[b]) begin
          w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_next_state     = S_IDLE;
    w_next_cnt       = r_cnt;
    w_next_read      = 1'b0;
    w_next_hreadyout = 1'b1;
    w_next_hresp     = 1'b0;
    w_next_hrdata    = '0;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_next_state = S_DATA;
          w_next_read  = !r_write;
        end else begin
          w_next_state = S_WAIT;
          w_next_cnt   = r_cnt - 2'd1;
        end
      end
      S_ERR1: begin
        w_next_state = S_ERR2;
      end
      default: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next_state = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_next_state = S_DATA;
            w_next_read  = !HWRITE;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = WAIT_INIT;
          end
        end
      end
    endcase
    w_next_hreadyout = (w_next_state != S_WAIT) && (w_next_state != S_ERR1);
    w_next_hresp     = (w_next_state == S_ERR1) || (w_next_state == S_ERR2);
    w_next_hrdata    = w_next_read ? w_rd_word : 32'd0;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_mask      <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_hreadyout <= w_next_hreadyout;
      r_hresp     <= w_next_hresp;
      r_hrdata    <= w_next_hrdata;
      if (w_accept) begin
        r_addr  <= HADDR[ADDR_MSB:ADDR_LSB];
        r_write <= HWRITE;
        r_mask  <= w_mask;
      end
    end
  end

  // Storage is not reset; writes commit on the edge that ends the DATA cycle.
  always_ff @(posedge HCLK) begin
    if (w_do_write) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (r_mask[b]) begin
          r_mem[r_addr][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahblite_mem_slave.sv
// Bench for ahblite_mem_slave: a pipelined AHB-Lite master drives a vector table into
// two instances (0 and 2 wait states) sharing one bus; a scoreboard checks data phases.
module tb_ahblite_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel1, hwrite, hready, dp_own;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  // Bus-wide HREADY comes from whichever slave owns the current data phase.
  assign hready = dp_own ? ro1 : ro0;

  ahblite_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahblite_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
  );

  typedef struct {
    logic        dut;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic        dut;
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  vec_t vec[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic d, input logic s, input logic [1:0] t, input logic w,
                     input logic [2:0] z, input logic [31:0] a, input logic [31:0] wd,
                     input logic e, input logic [31:0] rd);
    vec_t v;
    v.dut = d; v.sel = s; v.trans = t; v.wr = w; v.size = z;
    v.addr = a; v.wdata = wd; v.err = e; v.rdata = rd;
    vec.push_back(v);
  endtask

  function automatic logic get_ro(input logic d);
    return d ? ro1 : ro0;
  endfunction
  function automatic logic get_rs(input logic d);
    return d ? rs1 : rs0;
  endfunction
  function automatic logic [31:0] get_rd(input logic d);
    return d ? rd1 : rd0;
  endfunction

  task automatic drive_ap(input int i, input int hi);
    if (i <= hi) begin
      sel0   = vec[i].sel && (vec[i].dut == 1'b0);
      sel1   = vec[i].sel && (vec[i].dut == 1'b1);
      htrans = vec[i].trans;
      hwrite = vec[i].wr;
      hsize  = vec[i].size;
      haddr  = vec[i].addr;
    end else begin
      sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = '0;
    end
  endtask

  // Pipelined master: address phase of vector ap overlaps the data phase at the head of sb.
  task automatic run(input int lo, input int hi);
    int   ap  = lo;
    int   nw  = 0;
    int   cyc = 0;
    logic adv;
    exp_t cur;
    exp_t e;
    drive_ap(ap, hi);
    forever begin
      @(negedge clk);
      adv = hready;
      if (sb.size() != 0) begin
        cur = sb[0];
        if (!adv) begin
          nw++;
          check($sformatf("v%0d_stall_resp", cur.idx), 32'(get_rs(cur.dut)), 32'(cur.err));
          check($sformatf("v%0d_stall_rdata", cur.idx), get_rd(cur.dut), 32'd0);
        end else begin
          void'(sb.pop_front());
          check($sformatf("v%0d_resp", cur.idx), 32'(get_rs(cur.dut)), 32'(cur.err));
          check($sformatf("v%0d_waits", cur.idx), 32'(nw), 32'(cur.waits));
          check($sformatf("v%0d_rdata", cur.idx), get_rd(cur.dut),
                (cur.err || cur.wr) ? 32'd0 : cur.rdata);
          nw = 0;
        end
      end else begin
        check("idle_ready0", 32'(ro0), 32'd1);
        check("idle_resp1", 32'(rs1), 32'd0);
        check("idle_rdata0", rd0, 32'd0);
      end
      if (adv && (ap > hi)) break;
      @(posedge clk); #1;
      if (adv) begin
        if (ap <= hi) begin
          dp_own = vec[ap].dut;
          hwdata = vec[ap].wdata;
          if (vec[ap].sel && vec[ap].trans[1]) begin
            e.idx = ap; e.dut = vec[ap].dut; e.err = vec[ap].err; e.wr = vec[ap].wr;
            e.rdata = vec[ap].rdata;
            e.waits = vec[ap].err ? 1 : (vec[ap].dut ? 2 : 0);
            sb.push_back(e);
          end
        end else begin
          hwdata = $urandom;
        end
        ap++;
        drive_ap(ap, hi);
      end
      cyc++;
      if (cyc > 2000) begin
        checks++;
        failures++;
        $display("FAIL run_timeout: got %0d cycles expected at most 2000", cyc);
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; dp_own = 1'b0; hwdata = '0;
    drive_ap(1, 0);

    //   dut sel trans  wr size    addr          wdata         err  rdata
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 0, 32'h0);           // 0
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'hDEAD_BEEF);   // 1
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0004, 32'h1122_3344, 0, 32'h0);           // 2
    add(0, 1, 2'b11, 1, 3'b000, 32'h0000_0006, 32'h00AA_0000, 0, 32'h0);           // 3
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'h11AA_3344);   // 4
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h0);           // 5
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 1, 32'h0);           // 6
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0000, 32'h0,         0, 32'hCAFE_F00D);   // 7
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_1000, 32'h0,         1, 32'h0);           // 8
    add(0, 0, 2'b10, 1, 3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0);           // 9
    add(0, 1, 2'b01, 1, 3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'h0);           // 10
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0000, 32'h0,         0, 32'hCAFE_F00D);   // 11
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0008, 32'h0123_4567, 0, 32'h0);           // 12
    add(0, 1, 2'b10, 1, 3'b001, 32'h0000_000A, 32'hBEEF_0000, 0, 32'h0);           // 13
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0008, 32'h0,         0, 32'hBEEF_4567);   // 14
    add(0, 1, 2'b10, 0, 3'b001, 32'h0000_0009, 32'h0,         1, 32'h0);           // 15
    add(0, 1, 2'b10, 0, 3'b011, 32'h0000_0000, 32'h0,         1, 32'h0);           // 16
    add(0, 1, 2'b10, 1, 3'b010, 32'h0000_0FFC, 32'h0000_0000, 0, 32'h0);           // 17
    add(0, 1, 2'b10, 1, 3'b000, 32'h0000_0FFF, 32'h7700_0000, 0, 32'h0);           // 18
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0FFC, 32'h0,         0, 32'h7700_0000);   // 19
    add(0, 1, 2'b10, 0, 3'b000, 32'h0000_0001, 32'h0,         0, 32'hCAFE_F00D);   // 20
    add(1, 1, 2'b10, 1, 3'b010, 32'h0000_0010, 32'hA5A5_A5A5, 0, 32'h0);           // 21
    add(1, 1, 2'b10, 0, 3'b010, 32'h0000_0010, 32'h0,         0, 32'hA5A5_A5A5);   // 22
    add(1, 1, 2'b10, 0, 3'b010, 32'h0000_2000, 32'h0,         1, 32'h0);           // 23
    add(1, 1, 2'b10, 1, 3'b010, 32'h0000_0020, 32'h1234_5678, 0, 32'h0);           // 24
    add(1, 1, 2'b10, 1, 3'b001, 32'h0000_0012, 32'h5AA5_0000, 0, 32'h0);           // 25
    add(1, 1, 2'b10, 0, 3'b010, 32'h0000_0010, 32'h0,         0, 32'h5AA5_A5A5);   // 26
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0004, 32'h0,         0, 32'h11AA_3344);   // 27
    add(1, 1, 2'b10, 0, 3'b010, 32'h0000_0020, 32'h0,         0, 32'h1234_5678);   // 28
    add(1, 1, 2'b10, 0, 3'b010, 32'h0000_0020, 32'h0,         0, 32'h1234_5678);   // 29
    add(0, 1, 2'b10, 0, 3'b010, 32'h0000_0000, 32'h0,         0, 32'hCAFE_F00D);   // 30

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(ro0), 32'd1);
    check("rst_resp0",  32'(rs0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_ready1", 32'(ro1), 32'd1);
    check("rst_resp1",  32'(rs1), 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 28);

    // Reset pulse while instance 1 sits in the wait states of a write to 0x020.
    @(posedge clk); #1;
    dp_own = 1'b1; sel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h20;
    @(posedge clk); #1;
    drive_ap(1, 0);
    hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_mid_stalled", 32'(ro1), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ro1), 32'd1);
    check("rst_mid_resp",  32'(rs1), 32'd0);
    check("rst_mid_rdata", rd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dp_own = 1'b0;
    run(29, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
